// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared types and constants for the PWM breathing sequencer:
//            the FSM state encoding, the duty ceiling, the ordering-mode codes
//            and the default duty table loaded at reset.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_OFFER = 3'd2,
    ST_RUN   = 3'd3,
    ST_PAUSE = 3'd4
  } state_t;

  localparam int DUTY_MAX = 100;

  localparam logic MODE_WRAP     = 1'b0;
  localparam logic MODE_PINGPONG = 1'b1;

  localparam int DEFAULT_W       = 7;
  localparam int DEFAULT_ENTRIES = 10;

  // Entry 0 lives in the least significant slice.
  localparam logic [DEFAULT_ENTRIES*DEFAULT_W-1:0] DEFAULT_DUTY_TABLE = {
    7'd95, 7'd85, 7'd70, 7'd50, 7'd20,
    7'd20, 7'd50, 7'd70, 7'd85, 7'd95
  };

  // Default duty for a table slot; slots past the default list start at 0.
  function automatic logic [DEFAULT_W-1:0] default_duty(input int i);
    logic [DEFAULT_W-1:0] val;
    val = '0;
    if (i >= 0 && i < DEFAULT_ENTRIES) begin
      val = DEFAULT_DUTY_TABLE[i*DEFAULT_W +: DEFAULT_W];
    end
    return val;
  endfunction

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_step_timer.sv
`default_nettype none
// ============================================================================
// Module   : pwm_step_timer
// Purpose  : Period counter plus hold counter. While enabled, the period
//            counter runs 0..CLK_PER_PERIOD-1 and pulses period_tick on its
//            terminal count; the hold counter counts ticks and step_done
//            marks the tick that brings it to HOLD_PERIODS.
// Ports    : clk, rst        - clock, async active-high reset
//            enable          - advance counters this cycle
//            clear           - zero both counters (dominates enable)
//            period_tick     - terminal count of the period counter
//            step_done       - last tick of the hold interval
// Revision : 1.0 - initial release
// ============================================================================
module pwm_step_timer #(
  parameter int CLK_PER_PERIOD = 500_000,
  parameter int HOLD_PERIODS   = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic period_tick,
  output logic step_done
);

  localparam int CNT_W  = (CLK_PER_PERIOD > 1) ? $clog2(CLK_PER_PERIOD) : 1;
  localparam int HOLD_W = $clog2(HOLD_PERIODS + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_PER_PERIOD - 1);
  localparam logic [HOLD_W-1:0] HOLD_END  = HOLD_W'(HOLD_PERIODS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);

  logic [CNT_W-1:0]  period_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  assign period_tick = enable && (period_cnt == CNT_LAST);
  assign step_done   = period_tick && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
      hold_cnt   <= '0;
    end else if (clear) begin
      period_cnt <= '0;
      hold_cnt   <= '0;
    end else if (enable) begin
      if (period_cnt == CNT_LAST) begin
        period_cnt <= '0;
      end else begin
        period_cnt <= period_cnt + 1'b1;
      end
      // Saturate at the terminal hold count; the sequencer leaves RUN on
      // step_done so this only guards against a stray extra tick.
      if (period_tick && (hold_cnt != HOLD_END)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule : pwm_step_timer
`default_nettype wire

// File: rtl/pwm_breath_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pwm_breath_sequencer
// Purpose  : Steps through a programmable duty table, holds each entry for a
//            fixed number of PWM periods and hands every new duty to the PWM
//            core over a valid/ready handshake. Wrap or ping-pong ordering,
//            pause, stop and runtime table writes.
// Ports    : sys_clk, sys_rst             - clock, async active-high reset
//            start, stop                  - one-cycle control pulses
//            pause                        - level, freezes RUN
//            mode, last_idx               - ordering and end index (at start)
//            tbl_we, tbl_addr, tbl_wdata  - table write port
//            duty, duty_valid, duty_ready - handshake to the PWM core
//            step_idx                     - current/offered entry index
//            period_tick                  - PWM period end while RUN
//            busy                         - any state but IDLE
// Revision : 1.0 - initial release
// ============================================================================
module pwm_breath_sequencer
  import pwm_pkg::*;
#(
  parameter int CLK_PER_PERIOD = 500_000,
  parameter int HOLD_PERIODS   = 200,
  parameter int DEPTH          = 10,
  parameter int DUTY_W         = 7,
  parameter int IDX_W          = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              mode,
  input  logic [IDX_W-1:0]  last_idx,
  input  logic              tbl_we,
  input  logic [IDX_W-1:0]  tbl_addr,
  input  logic [DUTY_W-1:0] tbl_wdata,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  input  logic              duty_ready,
  output logic [IDX_W-1:0]  step_idx,
  output logic              period_tick,
  output logic              busy
);

  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(DEPTH - 1);
  localparam logic [DUTY_W-1:0] DUTY_SAT = DUTY_W'(DUTY_MAX);

  state_t state, state_nxt;

  logic [DUTY_W-1:0] tbl [DEPTH];

  logic [IDX_W-1:0] idx;
  logic             dir_down;
  logic             mode_q;
  logic [IDX_W-1:0] last_q;

  logic [IDX_W-1:0] idx_nxt;
  logic             dir_nxt;

  logic timer_en;
  logic timer_clr;
  logic step_done;

  // --------------------------------------------------------------------------
  // Step timer: runs only in RUN, frozen in PAUSE, zeroed everywhere else.
  // --------------------------------------------------------------------------
  assign timer_en  = (state == ST_RUN);
  assign timer_clr = stop || !((state == ST_RUN) || (state == ST_PAUSE));

  pwm_step_timer #(
    .CLK_PER_PERIOD (CLK_PER_PERIOD),
    .HOLD_PERIODS   (HOLD_PERIODS)
  ) u_step_timer (
    .clk         (sys_clk),
    .rst         (sys_rst),
    .enable      (timer_en),
    .clear       (timer_clr),
    .period_tick (period_tick),
    .step_done   (step_done)
  );

  // A stop withdraws a pending offer in the same cycle, so the PWM core never
  // sees a transfer that the sequencer is about to abandon.
  assign duty_valid = (state == ST_OFFER) && !stop;
  assign busy       = (state != ST_IDLE);

  // --------------------------------------------------------------------------
  // Next-index computation
  // --------------------------------------------------------------------------
  always_comb begin
    idx_nxt = idx;
    dir_nxt = dir_down;
    if (last_q == '0) begin
      idx_nxt = '0;
      dir_nxt = 1'b0;
    end else if (mode_q == MODE_WRAP) begin
      idx_nxt = (idx == last_q) ? '0 : idx + 1'b1;
      dir_nxt = 1'b0;
    end else if (!dir_down) begin
      // Ascending: turn around at the top without repeating it.
      if (idx >= last_q) begin
        idx_nxt = idx - 1'b1;
        dir_nxt = 1'b1;
      end else begin
        idx_nxt = idx + 1'b1;
      end
    end else begin
      // Descending: turn around at 0 without repeating it.
      if (idx == '0) begin
        idx_nxt = IDX_W'(1);
        dir_nxt = 1'b0;
      end else begin
        idx_nxt = idx - 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_OFFER;
      ST_OFFER: if (duty_ready) state_nxt = ST_RUN;
      ST_RUN: begin
        if (step_done) begin
          state_nxt = ST_FETCH;
        end else if (pause) begin
          state_nxt = ST_PAUSE;
        end
      end
      ST_PAUSE: if (!pause) state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
    // stop dominates everything, including a simultaneous start.
    if (stop) begin
      state_nxt = ST_IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencing registers
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      idx      <= '0;
      dir_down <= 1'b0;
      mode_q   <= MODE_WRAP;
      last_q   <= '0;
      duty     <= '0;
      step_idx <= '0;
    end else if (!stop) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx      <= '0;
            dir_down <= 1'b0;
            mode_q   <= mode;
            last_q   <= (last_idx > IDX_MAX) ? IDX_MAX : last_idx;
          end
        end
        ST_FETCH: begin
          // Reads the pre-edge table contents, so a same-cycle write to this
          // slot shows up only on the following fetch.
          duty     <= tbl[idx];
          step_idx <= idx;
        end
        ST_RUN: begin
          if (step_done) begin
            idx      <= idx_nxt;
            dir_down <= dir_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Duty table
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= DUTY_W'(default_duty(i));
      end
    end else if (tbl_we && (32'(tbl_addr) < DEPTH)) begin
      tbl[tbl_addr] <= (tbl_wdata > DUTY_SAT) ? DUTY_SAT : tbl_wdata;
    end
  end

endmodule : pwm_breath_sequencer
`default_nettype wire

// File: tb/tb_pwm_breath_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_breath_sequencer
// Purpose  : Directed self-checking bench for pwm_breath_sequencer with a
//            short period (4 clocks) and hold (3 periods).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_breath_sequencer;

  localparam int CPP  = 4;
  localparam int HOLD = 3;
  localparam int GAP  = CPP*HOLD + 2; // handshake edge + RUN + FETCH

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       start, stop, pause, mode;
  logic [3:0] last_idx;
  logic       tbl_we;
  logic [3:0] tbl_addr;
  logic [6:0] tbl_wdata;
  logic [6:0] duty;
  logic       duty_valid;
  logic       duty_ready;
  logic [3:0] step_idx;
  logic       period_tick;
  logic       busy;

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  pwm_breath_sequencer #(
    .CLK_PER_PERIOD (CPP),
    .HOLD_PERIODS   (HOLD),
    .DEPTH          (10),
    .DUTY_W         (7),
    .IDX_W          (4)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .mode        (mode),
    .last_idx    (last_idx),
    .tbl_we      (tbl_we),
    .tbl_addr    (tbl_addr),
    .tbl_wdata   (tbl_wdata),
    .duty        (duty),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .step_idx    (step_idx),
    .period_tick (period_tick),
    .busy        (busy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!duty_valid && n < 20) begin
      tick();
      n++;
    end
    if (!duty_valid) chk({tag, "_wait_valid_timeout"}, 0, 1);
  endtask

  task automatic go(input logic m, input int last);
    mode     = m;
    last_idx = 4'(last);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // At an offer (ready high): check the offer, then count edges and ticks
  // until the next offer appears.
  task automatic step(input string tag, input int ei, input int ed);
    int gap, nt;
    chk($sformatf("%s_valid", tag), int'(duty_valid), 1);
    chk($sformatf("%s_duty", tag), int'(duty), ed);
    chk($sformatf("%s_idx", tag), int'(step_idx), ei);
    gap = 0;
    nt  = 0;
    do begin
      tick();
      gap++;
      if (period_tick) nt++;
    end while (!duty_valid && gap < 100);
    chk($sformatf("%s_gap", tag), gap, GAP);
    chk($sformatf("%s_ticks", tag), nt, HOLD);
  endtask

  int exp1_d [4] = '{95, 85, 70, 95};
  int exp1_i [4] = '{0, 1, 2, 0};
  int exp2_d [8] = '{95, 85, 70, 50, 70, 85, 95, 85};
  int exp2_i [8] = '{0, 1, 2, 3, 2, 1, 0, 1};

  initial begin
    int nvalid, nstable, nticks, n, pticks;

    sys_rst    = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    pause      = 1'b0;
    mode       = 1'b0;
    last_idx   = 4'd0;
    tbl_we     = 1'b0;
    tbl_addr   = 4'd0;
    tbl_wdata  = 7'd0;
    duty_ready = 1'b1;
    repeat (3) tick();

    chk("rst_duty", int'(duty), 0);
    chk("rst_valid", int'(duty_valid), 0);
    chk("rst_idx", int'(step_idx), 0);
    chk("rst_tick", int'(period_tick), 0);
    chk("rst_busy", int'(busy), 0);
    sys_rst = 1'b0;
    tick();

    // 1: wrap, L=2
    go(1'b0, 2);
    wait_valid("t1");
    for (int i = 0; i < 4; i++) step($sformatf("t1_s%0d", i), exp1_i[i], exp1_d[i]);
    halt();
    chk("t1_idle", int'(busy), 0);

    // 2: ping-pong, L=3
    go(1'b1, 3);
    wait_valid("t2");
    for (int i = 0; i < 8; i++) step($sformatf("t2_s%0d", i), exp2_i[i], exp2_d[i]);
    halt();

    // 3: ready held low during OFFER
    duty_ready = 1'b0;
    go(1'b0, 2);
    wait_valid("t3");
    nvalid = 0; nstable = 0; nticks = 0;
    for (int i = 0; i < 20; i++) begin
      if (duty_valid) nvalid++;
      if (duty == 7'd95) nstable++;
      if (period_tick) nticks++;
      tick();
    end
    chk("t3_valid_held", nvalid, 20);
    chk("t3_duty_stable", nstable, 20);
    chk("t3_no_tick", nticks, 0);
    duty_ready = 1'b1;
    step("t3_release", 0, 95);
    halt();

    // 4: pause for 10 cycles from RUN cycle 5
    go(1'b0, 2);
    wait_valid("t4");
    tick();                 // handshake edge: now at RUN cycle 0
    n = 0; nticks = 0; pticks = 0;
    while (!duty_valid && n < 100) begin
      if (n == 5)  pause = 1'b1;
      if (n == 15) pause = 1'b0;
      if (period_tick) nticks++;
      if (n >= 6 && n <= 15 && period_tick) pticks++;
      tick();
      n++;
    end
    pause = 1'b0;
    chk("t4_latency", n, CPP*HOLD + 10 + 1);
    chk("t4_ticks", nticks, HOLD);
    chk("t4_paused_ticks", pticks, 0);
    chk("t4_next_duty", int'(duty), 85);
    halt();

    // 5: stop during an unaccepted offer; start+stop together
    duty_ready = 1'b0;
    go(1'b0, 2);
    wait_valid("t5");
    stop = 1'b1;
    #1;
    chk("t5_withdraw_now", int'(duty_valid), 0);
    tick();
    stop = 1'b0;
    chk("t5_valid_after", int'(duty_valid), 0);
    chk("t5_busy_after", int'(busy), 0);
    chk("t5_duty_kept", int'(duty), 95);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("t5_start_stop", int'(busy), 0);
    tick();
    chk("t5_still_idle", int'(busy), 0);
    duty_ready = 1'b1;

    // 6: table write with saturation, out-of-range write, reset mid-RUN
    go(1'b0, 2);
    wait_valid("t6");
    tick();                 // RUN on index 0
    tbl_we    = 1'b1;
    tbl_addr  = 4'd1;
    tbl_wdata = 7'd120;
    tick();
    tbl_addr  = 4'd12;
    tbl_wdata = 7'd5;
    tick();
    tbl_we    = 1'b0;
    wait_valid("t6_next");
    chk("t6_sat_duty", int'(duty), 100);
    chk("t6_sat_idx", int'(step_idx), 1);
    tick();                 // accept, now RUN on index 1
    tick();
    tick();
    sys_rst = 1'b1;
    #1;
    chk("t6_rst_duty", int'(duty), 0);
    chk("t6_rst_idx", int'(step_idx), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_valid", int'(duty_valid), 0);
    chk("t6_rst_tick", int'(period_tick), 0);
    tick();
    sys_rst = 1'b0;
    tick();
    go(1'b0, 1);
    wait_valid("t6_after_rst");
    step("t6_def0", 0, 95);
    step("t6_def1", 1, 85);
    halt();

    // L=0 re-offers index 0 every step in ping-pong too
    go(1'b1, 0);
    wait_valid("t7");
    step("t7_s0", 0, 95);
    step("t7_s1", 0, 95);
    halt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule : tb_pwm_breath_sequencer
`default_nettype wire

// File: doc/pwm_breath_sequencer.md
Name: pwm_breath_sequencer

Overview:
Scheduler that sequences the LED PWM duty-cycle datapath. It steps through a programmable duty table, holds each duty for a fixed number of PWM periods, and hands each new duty to the PWM core over a valid/ready handshake. It supports wrap or ping-pong (breathing) ordering, plus pause, stop and runtime table rewrites. It sits between the control/register logic and the PWM generator.

Parameters:
CLK_PER_PERIOD, 500_000, sys_clk cycles per PWM period (10 ms at 50 MHz)
HOLD_PERIODS, 200, PWM periods each table entry is held (2 s)
DEPTH, 10, duty table entries
DUTY_W, 7, duty width in percent units (legal 0..100)
IDX_W, 4, table index width, equal to $clog2(DEPTH)

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  reset
start  in  1  one-cycle pulse; begin sequence at index 0
stop  in  1  one-cycle pulse; abort to IDLE
pause  in  1  level; freezes sequencing while high
mode  in  1  0 = wrap, 1 = ping-pong; sampled at start
last_idx  in  IDX_W  final active index; sampled at start
tbl_we  in  1  table write strobe
tbl_addr  in  IDX_W  table write address
tbl_wdata  in  DUTY_W  table write data
duty  out  DUTY_W  duty offered to PWM core
duty_valid  out  1  duty is being offered
duty_ready  in  1  PWM core accepts duty
step_idx  out  IDX_W  index of the current or offered entry
period_tick  out  1  one-cycle pulse at each PWM period end while RUN
busy  out  1  high in any state except IDLE

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high (sys_clk, sys_rst).
- Reset values:
  - state=IDLE; duty=0; duty_valid=0; step_idx=0; period_tick=0; busy=0; all counters 0.
  - Table loads the package default 95,85,70,50,20,20,50,70,85,95. Entries at index 10 and above reset to 0.
- States: IDLE, FETCH, OFFER, RUN, PAUSE.
- IDLE:
  - start -> FETCH with idx=0, direction=up.
  - Latch mode. Latch last_idx, clamped to DEPTH-1.
- FETCH (1 cycle): duty <= table[idx], step_idx <= idx -> OFFER.
- OFFER:
  - duty_valid=1. duty and step_idx stay stable until the handshake.
  - Transfer occurs in the cycle where duty_valid and duty_ready are both high.
  - Next cycle: duty_valid=0, counters cleared, go to RUN.
  - Step timer does not run in OFFER.
- RUN:
  - Period counter counts 0..CLK_PER_PERIOD-1. period_tick pulses when the counter is at CLK_PER_PERIOD-1.
  - Hold counter increments on each period_tick.
  - On the tick that makes hold reach HOLD_PERIODS: compute next idx -> FETCH.
  - Step latency: FETCH is entered exactly CLK_PER_PERIOD*HOLD_PERIODS cycles after the RUN entry.
- Next index:
  - Wrap: 0..L, then 0.
  - Ping-pong: 0,1..L,L-1..1,0,1..., endpoints not repeated.
  - L=0: index stays at 0 in both modes, and the entry is re-offered every step.
- PAUSE:
  - pause high in RUN -> PAUSE. Counters freeze and period_tick=0.
  - pause low -> RUN, continuing from the frozen counts.
  - pause is ignored in IDLE, FETCH and OFFER; it takes effect on RUN entry.
- stop:
  - From any non-IDLE state -> IDLE next cycle. duty_valid drops immediately; an offer may be withdrawn without ready.
  - duty holds its last value. Counters clear.
  - start and stop in the same cycle: stop wins.
  - start while busy: ignored.
- Table writes:
  - Allowed in any state. Written on the clock edge.
  - A write to the index being fetched in the same cycle: FETCH reads the old value.
  - Writes to tbl_addr >= DEPTH are ignored.
  - tbl_wdata > 100 is stored saturated to 100.
- Widths:
  - Period counter is $clog2(CLK_PER_PERIOD) bits; hold counter is $clog2(HOLD_PERIODS+1) bits.
  - No wrap-around beyond the terminal counts.
- Reset mid-operation returns to the reset values; the table returns to its defaults.

Decomposition:
- Package pwm_pkg:
  - state enum
  - DUTY_MAX=100
  - DEFAULT_DUTY_TABLE constant (10 entries)
  - MODE_WRAP/MODE_PINGPONG constants
- One sub-module pwm_step_timer:
  - Period counter plus hold counter.
  - Inputs enable and clear; outputs period_tick and step_done.
- Sequencer FSM, index logic and table live in the top module.

Test Plan:
(all with CLK_PER_PERIOD=4, HOLD_PERIODS=3, duty_ready tied high unless noted)
1. Reset then start, mode=0, L=2 -> offers duty 95,85,70,95, each accepted and followed by 12 RUN cycles. period_tick pulses 3 times per step.
2. mode=1, L=3 -> step_idx sequence 0,1,2,3,2,1,0,1 with duties 95,85,70,50,70,85,95,85.
3. duty_ready held low 20 cycles during OFFER -> duty_valid stays 1, duty stable at 95, no period_tick. Ready high -> RUN starts the next cycle.
4. pause high for 10 cycles at RUN cycle 5 -> step ends at cycle 22 after RUN entry instead of 12, and no ticks while paused.
5. stop during OFFER with ready low -> duty_valid=0 and busy=0 next cycle. start and stop together -> stays IDLE.
6. Write table[1]=120 while RUN on index 0 -> next offer is duty 100. A write to addr 12 leaves the table unchanged. Asserting sys_rst mid-RUN -> all outputs 0 and table[0]=95.
